// File: rtl/dma_burst_buffer_pkg.sv
// Shared AXI widths and response encodings used by the DMA burst buffer.
// The response check lives here so every consumer classifies beats the same way.
package dma_burst_buffer_pkg;

    localparam int AXI_DATA_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than OKAY marks the transfer as suspect.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dma_buf_mem.sv
// Beat storage for the DMA burst buffer: one synchronous write port and one
// asynchronous read port, no reset on the array.
module dma_buf_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_burst_buffer.sv
// Store-and-forward buffer between an AXI read data channel and a write data
// channel: a write burst is only offered once a complete read burst is held.
module dma_burst_buffer
    import dma_burst_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = AXI_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_resp,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   bursts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DATA_W:0] rd_word;
    logic            accept;
    logic            xfer;
    logic            burst_in;
    logic            burst_out;

    // Handshakes are gated by rst so nothing is offered or taken during reset.
    assign in_ready  = rst && (level != CW'(DEPTH)) && !flush;
    assign out_valid = rst && (bursts != '0) && !flush;

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign burst_in  = accept && in_last;
    assign burst_out = xfer && out_last;

    dma_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata ({in_last, in_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign out_last = rd_word[DATA_W];
    assign out_data = rd_word[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            bursts <= '0;
            rd_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            bursts <= '0;
            rd_err <= 1'b0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (xfer)   rd_ptr <= rd_ptr + AW'(1);

            case ({accept, xfer})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase

            case ({burst_in, burst_out})
                2'b10:   bursts <= bursts + CW'(1);
                2'b01:   bursts <= bursts - CW'(1);
                default: bursts <= bursts;
            endcase

            if (accept && resp_is_err(in_resp)) rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_burst_buffer.sv
// Directed bench for dma_burst_buffer: a queue model predicts handshakes,
// level, burst count, error flag and output data every cycle.
module tb_dma_burst_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_resp;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic [CW-1:0]     bursts;
    logic [CW-1:0]     level;
    logic              rd_err;

    dma_burst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_resp   (in_resp),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .bursts    (bursts),
        .level     (level),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W:0] q[$];
    int              exp_level  = 0;
    int              exp_bursts = 0;
    logic            exp_err    = 1'b0;
    logic            last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_level  = 0;
        exp_bursts = 0;
        exp_err    = 1'b0;
    endtask

    // One clock: check at the falling edge, then apply the predicted handshakes.
    task automatic tick();
        logic exp_ir, exp_ov, acc, xf, popped_last;
        @(negedge clk);
        exp_ir = (exp_level != DEPTH) && !flush;
        exp_ov = (exp_bursts != 0) && !flush;
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("level", level, exp_level);
        chk("bursts", bursts, exp_bursts);
        chk("rd_err", rd_err, exp_err);
        if (exp_ov && q.size() > 0) begin
            chk("out_data", out_data, q[0][DATA_W-1:0]);
            chk("out_last", out_last, q[0][DATA_W]);
        end
        acc = in_valid && exp_ir;
        xf  = exp_ov && out_ready && (q.size() > 0);
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else begin
            if (xf) begin
                popped_last = q[0][DATA_W];
                void'(q.pop_front());
                exp_level--;
                if (popped_last) exp_bursts--;
            end
            if (acc) begin
                q.push_back({in_last, in_data});
                exp_level++;
                if (in_last) exp_bursts++;
                if (in_resp != 2'b00) exp_err = 1'b1;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l, input logic [1:0] r);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_resp  = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int j;
        int guard;
        rst       = 1'b0;
        in_data   = '0;
        in_resp   = 2'b00;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;

        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_bursts", bursts, 0);
        chk("rst_rd_err", rd_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        // Single 4-beat burst streamed straight through.
        out_ready = 1'b1;
        send(32'h11, 1'b0, 2'b00);
        send(32'h22, 1'b0, 2'b00);
        send(32'h33, 1'b0, 2'b00);
        send(32'h44, 1'b1, 2'b00);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1'b1);
        chk("first_out_data", out_data, 32'h11);
        @(posedge clk);
        #1;
        q.delete();
        exp_level  = 3;
        exp_bursts = 1;
        q.push_back({1'b0, 32'h22});
        q.push_back({1'b0, 32'h33});
        q.push_back({1'b1, 32'h44});
        idle(4);
        chk("t1_bursts_zero", bursts, 0);

        // Fill to DEPTH with the write side stalled, then drain in DEPTH cycles.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(32'h1000 + i, i == DEPTH - 1, 2'b00);
        chk("full_level", level, DEPTH);
        chk("full_bursts", bursts, 1);
        send(32'hDEAD, 1'b1, 2'b00);
        out_ready = 1'b1;
        idle(DEPTH);
        chk("drained_level", level, 0);
        idle(1);

        // Partial burst must not be offered until its last beat arrives.
        send(32'hA1, 1'b0, 2'b00);
        send(32'hA2, 1'b0, 2'b00);
        send(32'hA3, 1'b0, 2'b00);
        idle(2);
        chk("partial_out_valid", out_valid, 1'b0);
        send(32'hA4, 1'b1, 2'b00);
        chk("partial_bursts", bursts, 1);
        idle(6);

        // Single-beat bursts: fill, then stream through a full buffer across the wrap.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(32'h100 + i, 1'b1, 2'b00);
        out_ready = 1'b1;
        j = 0;
        guard = 0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_resp  = 2'b00;
        while (j < 24 && guard < 100) begin
            in_data = 32'h200 + j;
            tick();
            if (last_acc) j++;
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_beats", j, 24);
        chk("stream_level", level, DEPTH - 1);
        idle(DEPTH + 1);
        chk("stream_drained", level, 0);

        // Error response on beat 2, sticky until flush.
        out_ready = 1'b0;
        send(32'hB1, 1'b0, 2'b00);
        send(32'hB2, 1'b0, 2'b10);
        chk("err_set", rd_err, 1'b1);
        send(32'hB3, 1'b0, 2'b00);
        send(32'hB4, 1'b1, 2'b00);
        idle(2);
        chk("err_sticky", rd_err, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_bursts", bursts, 0);
        chk("flush_rd_err", rd_err, 1'b0);
        idle(1);

        // Reset mid-burst after five beats, then a fresh burst.
        send(32'hC1, 1'b0, 2'b00);
        send(32'hC2, 1'b1, 2'b11);
        send(32'hC3, 1'b0, 2'b00);
        send(32'hC4, 1'b0, 2'b00);
        send(32'hC5, 1'b0, 2'b00);
        chk("pre_rst_level", level, 5);
        rst = 1'b0;
        #2;
        chk("rst_mid_in_ready", in_ready, 1'b0);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_bursts", bursts, 0);
        chk("rst_mid_rd_err", rd_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        send(32'hD1, 1'b0, 2'b00);
        send(32'hD2, 1'b1, 2'b00);
        idle(4);
        chk("final_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
